// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller that takes one instruction at a
// time, reads its operands from an external 8x8 register file, drives an
// external 8-bit ALU for a programmable number of settle cycles and writes
// the result back. Every output is registered and follows the FSM state.
module alu_op_sequencer #(
  parameter int unsigned LOGIC_CYCLES = 1,  // EXEC cycles for loadi/mov/and/or
  parameter int unsigned ADD_CYCLES   = 2   // EXEC cycles for add/sub
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] opcode,
  input  logic [2:0] dest,
  input  logic [2:0] src1,
  input  logic [2:0] src2,
  input  logic [7:0] imm,
  output logic [2:0] rf_out1addr,
  output logic [2:0] rf_out2addr,
  input  logic [7:0] rf_out1,
  input  logic [7:0] rf_out2,
  output logic [2:0] rf_inaddr,
  output logic [7:0] rf_in,
  output logic       rf_write_en,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_select,
  input  logic [7:0] alu_result,
  output logic       done,
  output logic       illegal,
  output logic [7:0] retired_count
);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  // Two's-complement negate modulo 256; sub is executed as add of this value.
  function automatic logic [7:0] twos_neg(input logic [7:0] v);
    return (~v) + 8'd1;
  endfunction

  state_t     state_q,         state_d;
  logic [7:0] opcode_q,        opcode_d;
  logic [2:0] dest_q,          dest_d;
  logic [7:0] imm_q,           imm_d;
  logic [7:0] cnt_q,           cnt_d;
  logic       instr_ready_q,   instr_ready_d;
  logic [2:0] rf_out1addr_q,   rf_out1addr_d;
  logic [2:0] rf_out2addr_q,   rf_out2addr_d;
  logic [2:0] rf_inaddr_q,     rf_inaddr_d;
  logic [7:0] rf_in_q,         rf_in_d;
  logic       rf_write_en_q,   rf_write_en_d;
  logic [7:0] alu_data1_q,     alu_data1_d;
  logic [7:0] alu_data2_q,     alu_data2_d;
  logic [2:0] alu_select_q,    alu_select_d;
  logic       done_q,          done_d;
  logic       illegal_q,       illegal_d;
  logic [7:0] retired_count_q, retired_count_d;

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so they are valid for the whole of that state's cycle.
  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    dest_d          = dest_q;
    imm_d           = imm_q;
    cnt_d           = cnt_q;
    instr_ready_d   = instr_ready_q;
    rf_out1addr_d   = rf_out1addr_q;
    rf_out2addr_d   = rf_out2addr_q;
    rf_inaddr_d     = rf_inaddr_q;
    rf_in_d         = rf_in_q;
    rf_write_en_d   = 1'b0;
    alu_data1_d     = alu_data1_q;
    alu_data2_d     = alu_data2_q;
    alu_select_d    = alu_select_q;
    done_d          = 1'b0;
    illegal_d       = 1'b0;
    retired_count_d = retired_count_q;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          opcode_d      = opcode;
          dest_d        = dest;
          imm_d         = imm;
          rf_out1addr_d = src1;
          rf_out2addr_d = src2;
          instr_ready_d = 1'b0;
          if (opcode <= OP_OR) begin
            state_d = S_DECODE;
          end else begin
            state_d   = S_ERR;
            illegal_d = 1'b1;
          end
        end
      end

      S_DECODE: begin
        // Operands captured here, so a write to dest==src in WB cannot
        // disturb the instruction in flight.
        alu_data1_d = rf_out1;
        case (opcode_q)
          OP_LOADI: begin alu_select_d = SEL_FWD; alu_data2_d = imm_q;             end
          OP_MOV:   begin alu_select_d = SEL_FWD; alu_data2_d = rf_out2;           end
          OP_ADD:   begin alu_select_d = SEL_ADD; alu_data2_d = rf_out2;           end
          OP_SUB:   begin alu_select_d = SEL_ADD; alu_data2_d = twos_neg(rf_out2); end
          OP_AND:   begin alu_select_d = SEL_AND; alu_data2_d = rf_out2;           end
          OP_OR:    begin alu_select_d = SEL_OR;  alu_data2_d = rf_out2;           end
          default:  begin alu_select_d = alu_select_q; alu_data2_d = alu_data2_q;  end
        endcase
        if ((opcode_q == OP_ADD) || (opcode_q == OP_SUB)) begin
          cnt_d = 8'(ADD_CYCLES);
        end else begin
          cnt_d = 8'(LOGIC_CYCLES);
        end
        state_d = S_EXEC;
      end

      S_EXEC: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          rf_in_d       = alu_result;
          rf_inaddr_d   = dest_q;
          rf_write_en_d = 1'b1;
          done_d        = 1'b1;
          state_d       = S_WB;
        end
      end

      S_WB: begin
        retired_count_d = retired_count_q + 8'd1;
        instr_ready_d   = 1'b1;
        state_d         = S_IDLE;
      end

      S_ERR: begin
        instr_ready_d = 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        instr_ready_d = 1'b1;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and reopens the input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= S_IDLE;
      opcode_q        <= '0;
      dest_q          <= '0;
      imm_q           <= '0;
      cnt_q           <= '0;
      instr_ready_q   <= 1'b1;
      rf_out1addr_q   <= '0;
      rf_out2addr_q   <= '0;
      rf_inaddr_q     <= '0;
      rf_in_q         <= '0;
      rf_write_en_q   <= 1'b0;
      alu_data1_q     <= '0;
      alu_data2_q     <= '0;
      alu_select_q    <= '0;
      done_q          <= 1'b0;
      illegal_q       <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      opcode_q        <= opcode_d;
      dest_q          <= dest_d;
      imm_q           <= imm_d;
      cnt_q           <= cnt_d;
      instr_ready_q   <= instr_ready_d;
      rf_out1addr_q   <= rf_out1addr_d;
      rf_out2addr_q   <= rf_out2addr_d;
      rf_inaddr_q     <= rf_inaddr_d;
      rf_in_q         <= rf_in_d;
      rf_write_en_q   <= rf_write_en_d;
      alu_data1_q     <= alu_data1_d;
      alu_data2_q     <= alu_data2_d;
      alu_select_q    <= alu_select_d;
      done_q          <= done_d;
      illegal_q       <= illegal_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign instr_ready   = instr_ready_q;
  assign rf_out1addr   = rf_out1addr_q;
  assign rf_out2addr   = rf_out2addr_q;
  assign rf_inaddr     = rf_inaddr_q;
  assign rf_in         = rf_in_q;
  assign rf_write_en   = rf_write_en_q;
  assign alu_data1     = alu_data1_q;
  assign alu_data2     = alu_data2_q;
  assign alu_select    = alu_select_q;
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural register file and ALU around
// the DUT, table of instructions with hand-derived results, scoreboard of
// expected write-backs, and directed sequences for illegal opcodes,
// back-to-back issue, reset abort and retired-count wrap.
module tb_alu_op_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [2:0] dest, src1, src2;
  logic [7:0] imm;
  logic [2:0] rf_out1addr, rf_out2addr, rf_inaddr;
  logic [7:0] rf_out1, rf_out2, rf_in;
  logic       rf_write_en;
  logic [7:0] alu_data1, alu_data2;
  logic [2:0] alu_select;
  logic [7:0] alu_result;
  logic       done, illegal;
  logic [7:0] retired_count;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rf [0:7];
  logic [10:0] sb_q [$];

  alu_op_sequencer #(.LOGIC_CYCLES(1), .ADD_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2), .imm(imm),
    .rf_out1addr(rf_out1addr), .rf_out2addr(rf_out2addr),
    .rf_out1(rf_out1), .rf_out2(rf_out2),
    .rf_inaddr(rf_inaddr), .rf_in(rf_in), .rf_write_en(rf_write_en),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .alu_result(alu_result),
    .done(done), .illegal(illegal), .retired_count(retired_count)
  );

  always #5 CLK = ~CLK;

  // Register file model: asynchronous read, write on rising edge.
  assign rf_out1 = rf[rf_out1addr];
  assign rf_out2 = rf[rf_out2addr];
  always @(posedge CLK) if (rf_write_en) rf[rf_inaddr] <= rf_in;

  // ALU model: fwd passes operand 2 (immediate / source 2).
  always_comb begin
    alu_result = 8'h00;
    case (alu_select)
      3'b000: alu_result = alu_data2;
      3'b001: alu_result = alu_data1 + alu_data2;
      3'b010: alu_result = alu_data1 & alu_data2;
      3'b011: alu_result = alu_data1 | alu_data2;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write-back must match the oldest expected entry.
  always @(negedge CLK) begin
    logic [10:0] e;
    if (rf_write_en || done) check("done_with_write", done, rf_write_en);
    if (illegal) check("illegal_no_write", rf_write_en, 1'b0);
    if (rf_write_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", rf_inaddr, rf_in);
      end else begin
        e = sb_q.pop_front();
        check("wb_addr", rf_inaddr, e[10:8]);
        check("wb_data", rf_in, e[7:0]);
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (!instr_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!instr_ready) check("ready_timeout", instr_ready, 1'b1);
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] d, s1, s2, input logic [7:0] im);
    opcode = op; dest = d; src1 = s1; src2 = s2; imm = im;
    instr_valid = 1'b1;
  endtask

  // Issue one instruction, check EXEC-phase ALU drive and accept-to-write latency.
  task automatic run_instr(input logic [7:0] op, input logic [2:0] d, s1, s2,
                           input logic [7:0] im, input int n,
                           input logic [2:0] esel, input logic [7:0] ed2,
                           input logic [7:0] eres);
    int k;
    wait_ready();
    sb_q.push_back({d, eres});
    drive(op, d, s1, s2, im);
    @(posedge CLK);
    @(negedge CLK);
    instr_valid = 1'b0;
    k = 1;
    while (!rf_write_en && k < 20) begin
      if (k == 2) begin
        check("exec_alu_select", alu_select, esel);
        check("exec_alu_data2", alu_data2, ed2);
      end
      @(negedge CLK);
      k++;
    end
    check("accept_to_write", k, 2 + n);
  endtask

  typedef struct {
    logic [7:0] op;
    logic [2:0] d, s1, s2;
    logic [7:0] im;
    int         n;
    logic [2:0] sel;
    logic [7:0] d2;
    logic [7:0] res;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    //           op     d     s1    s2    imm    n  sel   d2     res
    tbl[0]  = '{8'h00, 3'd1, 3'd0, 3'd0, 8'h0F, 1, 3'd0, 8'h0F, 8'h0F};
    tbl[1]  = '{8'h00, 3'd2, 3'd0, 3'd0, 8'h03, 1, 3'd0, 8'h03, 8'h03};
    tbl[2]  = '{8'h03, 3'd4, 3'd1, 3'd2, 8'h00, 2, 3'd1, 8'hFD, 8'h0C};
    tbl[3]  = '{8'h00, 3'd1, 3'd0, 3'd0, 8'hFF, 1, 3'd0, 8'hFF, 8'hFF};
    tbl[4]  = '{8'h00, 3'd2, 3'd0, 3'd0, 8'h02, 1, 3'd0, 8'h02, 8'h02};
    tbl[5]  = '{8'h02, 3'd5, 3'd1, 3'd2, 8'h00, 2, 3'd1, 8'h02, 8'h01};
    tbl[6]  = '{8'h00, 3'd1, 3'd0, 3'd0, 8'hF0, 1, 3'd0, 8'hF0, 8'hF0};
    tbl[7]  = '{8'h00, 3'd2, 3'd0, 3'd0, 8'h3C, 1, 3'd0, 8'h3C, 8'h3C};
    tbl[8]  = '{8'h04, 3'd6, 3'd1, 3'd2, 8'h00, 1, 3'd2, 8'h3C, 8'h30};
    tbl[9]  = '{8'h05, 3'd7, 3'd1, 3'd2, 8'h00, 1, 3'd3, 8'h3C, 8'hFC};
    tbl[10] = '{8'h01, 3'd0, 3'd7, 3'd7, 8'h00, 1, 3'd0, 8'hFC, 8'hFC};
    tbl[11] = '{8'h03, 3'd3, 3'd1, 3'd3, 8'h00, 2, 3'd1, 8'h00, 8'hF0};
    tbl[12] = '{8'h00, 3'd2, 3'd0, 3'd0, 8'h80, 1, 3'd0, 8'h80, 8'h80};
    tbl[13] = '{8'h03, 3'd3, 3'd1, 3'd2, 8'h00, 2, 3'd1, 8'h80, 8'h70};
    tbl[14] = '{8'h02, 3'd1, 3'd1, 3'd1, 8'h00, 2, 3'd1, 8'hF0, 8'hE0};

    RESET = 1'b1;
    instr_valid = 1'b0;
    opcode = 8'h00; dest = 3'd0; src1 = 3'd0; src2 = 3'd0; imm = 8'h00;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_we", rf_write_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_count", retired_count, 8'h00);
    RESET = 1'b0;

    // Table-driven instructions.
    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].im,
                tbl[i].n, tbl[i].sel, tbl[i].d2, tbl[i].res);
      @(negedge CLK);
      check("retired_count", retired_count, 8'(i + 1));
    end

    // Illegal opcodes: one-cycle illegal pulse, no write, count unchanged.
    for (int j = 0; j < 2; j++) begin
      wait_ready();
      drive((j == 0) ? 8'h07 : 8'hFF, 3'd2, 3'd1, 3'd1, 8'h55);
      @(posedge CLK);
      @(negedge CLK);
      instr_valid = 1'b0;
      check("err_illegal", illegal, 1'b1);
      check("err_ready", instr_ready, 1'b0);
      @(negedge CLK);
      check("err_illegal_clear", illegal, 1'b0);
      check("err_ready_back", instr_ready, 1'b1);
      check("err_count", retired_count, 8'd15);
    end

    // Back-to-back: second instruction held valid (fields changed while busy).
    begin
      int k;
      wait_ready();
      sb_q.push_back({3'd5, 8'h11});
      sb_q.push_back({3'd6, 8'h22});
      drive(8'h00, 3'd5, 3'd0, 3'd0, 8'h11);
      @(posedge CLK);
      @(negedge CLK);
      drive(8'h00, 3'd6, 3'd0, 3'd0, 8'h22);
      k = 1;
      while (!instr_ready && k < 20) begin
        @(negedge CLK);
        k++;
      end
      check("b2b_accept_gap", k, 4);
      @(posedge CLK);
      @(negedge CLK);
      instr_valid = 1'b0;
      check("b2b_accepted", instr_ready, 1'b0);
      k = 1;
      while (!rf_write_en && k < 20) begin
        @(negedge CLK);
        k++;
      end
      check("b2b_second_latency", k, 3);
      @(negedge CLK);
      check("b2b_count", retired_count, 8'd17);
    end

    // Reset during EXEC of add: aborts with no write-back.
    wait_ready();
    drive(8'h02, 3'd7, 3'd1, 3'd2, 8'h00);
    @(posedge CLK);
    @(negedge CLK);
    instr_valid = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_ready", instr_ready, 1'b1);
    check("abort_count", retired_count, 8'h00);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (rf_write_en || done) seen++;
      @(negedge CLK);
    end
    check("abort_no_wb", seen, 0);

    // Retired-count wrap after 256 instructions.
    for (int i = 0; i < 256; i++) begin
      run_instr(8'h00, 3'(i), 3'd0, 3'd0, 8'(i), 1, 3'd0, 8'(i), 8'(i));
      @(negedge CLK);
      if (i == 254) check("count_255", retired_count, 8'hFF);
    end
    check("count_wrap", retired_count, 8'h00);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
